branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Parametrised successor to the single-cycle branch unit, placed in the execute stage.
//  Resolves all six RV32I conditional branches plus jal/jalr and computes the redirect target.
//  Issues a registered redirect and a multi-cycle pipeline flush.
//  Trains a 2-bit-counter branch history table (BHT) that fetch reads for prediction.
// PARAMETERS
//  XLEN          32  datapath/PC width
//  BHT_ENTRIES   64  BHT depth; power of 2, >=2; index = pc[log2(BHT_ENTRIES)+1:2]
//  FLUSH_CYCLES  2   cycles flush stays high per redirect; >=1
//  CNT_W         32  performance counter width
// PORTS
//  clock            in   1      single clock, rising edge
//  reset            in   1      synchronous, active-low
//  valid_in         in   1      execute-stage instruction valid (0 = nop/bubble)
//  opCode           in   7      instruction opcode (bOp, jalOp, jalrOp from parameters.vh)
//  funct3           in   3      branch condition select
//  pc               in   XLEN   PC of the executing instruction
//  imm              in   XLEN   sign-extended immediate
//  operand1         in   XLEN   rs1 value
//  operand2         in   XLEN   rs2 value
//  pred_taken       in   1      direction fetch predicted for this instruction
//  fetch_pc         in   XLEN   PC being fetched (BHT lookup)
//  predict_taken    out  1      BHT prediction for fetch_pc (combinational read)
//  PCsrc            out  1      registered redirect strobe, 1 cycle
//  redirect_pc      out  XLEN   registered redirect target, valid while PCsrc=1
//  flush            out  1      kill younger instructions in fetch/decode
//  link_addr        out  XLEN   pc+4, combinational, for jal/jalr rd write-back
//  branch_count     out  CNT_W  resolved conditional branches, saturating
//  mispredict_count out  CNT_W  redirects issued, saturating
// BEHAVIOUR
//  Reset: PCsrc=0, redirect_pc=0, flush=0, both counters=0, FSM=IDLE, every BHT entry=2'b01.
//  Conditions (signed unless noted): beq ==, bne !=, blt <, bge >=, bltu <u, bgeu >=u.
//   funct3 010/011 under bOp -> not taken, no BHT update, still counted.
//  Targets: branch/jal = pc+imm; jalr = (operand1+imm) & ~1; all mod 2^XLEN, wrap silently.
//  A resolve event occurs when valid_in=1 and FSM=IDLE.
//   Resolve is ignored in FLUSH, because those instructions are wrong-path.
//  redirect = jal | jalr | (bOp & taken != pred_taken).
//  Redirect target = taken ? target : pc+4.
//  FSM IDLE: a resolve with redirect=1 sets, at the next edge:
//   PCsrc=1, redirect_pc=target, flush=1, cnt=FLUSH_CYCLES-1, state -> FLUSH.
//  FSM FLUSH: PCsrc=0; flush stays 1; state -> IDLE when cnt==0, else cnt-1.
//   Net effect: flush is high exactly FLUSH_CYCLES cycles and PCsrc exactly 1 cycle.
//  Latency: one cycle from the resolving edge to PCsrc/redirect_pc/flush.
//  BHT update on a bOp resolve with valid funct3: saturating +1 if taken, -1 if not.
//   11 stays 11; 00 stays 00.
//  predict_taken = BHT[fetch_pc index][1].
//   A same-cycle update to the same index returns the OLD value; the new value is visible next cycle.
//  Counters: branch_count +1 per bOp resolve; mispredict_count +1 per redirect.
//   Both hold at 2^CNT_W-1.
//  valid_in=0: no redirect, no update, no count.
//  Reset asserted mid-FLUSH: everything returns to reset values at that edge.
// TESTING
//  1 beq, op1=op2=5, pc=0x100, imm=0x20, pred_taken=0 -> next cycle PCsrc=1, redirect_pc=0x120,
//    flush high 2 cycles; entry 0 goes 01->10.
//  2 blt, op1=0xFFFFFFFF, op2=1, pred_taken=1 -> taken (signed), no redirect.
//    bltu with same operands and pred_taken=1 -> redirect_pc=pc+4.
//  3 jalr, op1=0x203, imm=0x10, pc=0x40 -> redirect_pc=0x212, link_addr=0x44;
//    a second valid jal on the next cycle is ignored (FLUSH), no count increments.
//  4 Four taken bne at pc=0x8 -> BHT[2] saturates at 11, predict_taken=1 for fetch_pc=0x8;
//    entry aliasing at 0x8+4*BHT_ENTRIES is observed.
//  5 Redirect issued, then reset=0 in the first FLUSH cycle -> flush=0, PCsrc=0, counters=0 next edge.
//  6 CNT_W=4: 20 mispredicting branches -> mispredict_count=15, branch_count=15.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: evaluates RV32I branches and jal/jalr, issues a registered
// redirect with a multi-cycle flush, and trains the 2-bit BHT that fetch reads for prediction.
module branch_resolve_unit #(
  parameter int         XLEN         = 32,
  parameter int         BHT_ENTRIES  = 64,
  parameter int         FLUSH_CYCLES = 2,
  parameter int         CNT_W        = 32,
  parameter logic [6:0] B_OP         = 7'b1100011,
  parameter logic [6:0] JAL_OP       = 7'b1101111,
  parameter logic [6:0] JALR_OP      = 7'b1100111
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [6:0]      opCode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            predict_taken,
  output logic            PCsrc,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [XLEN-1:0] link_addr,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic             pcsrc_q, pcsrc_d;
  logic             flush_q, flush_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];

  logic             is_branch, is_jal, is_jalr, cond_valid, cond_true;
  logic             taken, resolve, redirect;
  logic [XLEN-1:0]  target, redirect_target, fall_through;
  logic [IDX_W-1:0] upd_idx, fetch_idx;
  logic [1:0]       upd_cur;
  logic             unused_fetch_bits;

  assign fall_through      = pc + XLEN'(4);
  assign upd_idx           = pc[IDX_W+1:2];
  assign fetch_idx         = fetch_pc[IDX_W+1:2];
  assign unused_fetch_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0]};

  // NOTE: every always_comb output gets a default at the top so no path can infer a latch.
  always_comb begin
    is_branch  = (opCode == B_OP);
    is_jal     = (opCode == JAL_OP);
    is_jalr    = (opCode == JALR_OP);
    cond_valid = (funct3 != 3'b010) && (funct3 != 3'b011);
    cond_true  = 1'b0;
    case (funct3)
      3'b000:  cond_true = (operand1 == operand2);
      3'b001:  cond_true = (operand1 != operand2);
      3'b100:  cond_true = ($signed(operand1) <  $signed(operand2));
      3'b101:  cond_true = ($signed(operand1) >= $signed(operand2));
      3'b110:  cond_true = (operand1 <  operand2);
      3'b111:  cond_true = (operand1 >= operand2);
      default: cond_true = 1'b0;
    endcase
    taken    = is_jal || is_jalr || (is_branch && cond_true);
    resolve  = valid_in && (state_q == ST_IDLE);
    redirect = resolve && (is_jal || is_jalr || (is_branch && (cond_true != pred_taken)));
    target   = is_jalr ? ((operand1 + imm) & ~XLEN'(1)) : (pc + imm);
    redirect_target = taken ? target : fall_through;
  end

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    pcsrc_d       = 1'b0;
    flush_d       = flush_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          pcsrc_d       = 1'b1;
          redirect_pc_d = redirect_target;
          flush_d       = 1'b1;
          fcnt_d        = FC_LAST;
          state_d       = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) begin
          flush_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (resolve && is_branch && (branch_count_q != {CNT_W{1'b1}}))
      branch_count_d = branch_count_q + 1'b1;
    if (redirect && (mispredict_count_q != {CNT_W{1'b1}}))
      mispredict_count_d = mispredict_count_q + 1'b1;
  end

  always_comb begin
    bht_d   = bht_q;
    upd_cur = bht_q[upd_idx];
    if (resolve && is_branch && cond_valid) begin
      if (cond_true && (upd_cur != 2'b11))
        bht_d[upd_idx] = upd_cur + 2'b01;
      else if (!cond_true && (upd_cur != 2'b00))
        bht_d[upd_idx] = upd_cur - 2'b01;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q            <= ST_IDLE;
      fcnt_q             <= '0;
      pcsrc_q            <= 1'b0;
      flush_q            <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      // NOTE: the BHT must start weakly-not-taken, so this storage is reset like ordinary flops.
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      state_q            <= state_d;
      fcnt_q             <= fcnt_d;
      pcsrc_q            <= pcsrc_d;
      flush_q            <= flush_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      bht_q              <= bht_d;
    end
  end

  // Read from the registered table: a same-cycle update is seen by fetch one cycle later.
  assign predict_taken    = bht_q[fetch_idx][1];
  assign PCsrc            = pcsrc_q;
  assign redirect_pc      = redirect_pc_q;
  assign flush            = flush_q;
  assign link_addr        = fall_through;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized traffic
// checked against a behavioural model of the resolve/flush/BHT rules.
module tb_branch_resolve_unit;

  localparam logic [6:0] B_OP    = 7'b1100011;
  localparam logic [6:0] JAL_OP  = 7'b1101111;
  localparam logic [6:0] JALR_OP = 7'b1100111;
  localparam logic [6:0] ALU_OP  = 7'b0110011;
  localparam int         FLUSH_N = 2;
  localparam int         BHT_N   = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [6:0]  opCode = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] pc = '0, imm = '0, operand1 = '0, operand2 = '0, fetch_pc = '0;
  logic        pred_taken = 1'b0;
  logic        predict_taken, PCsrc, flush;
  logic [31:0] redirect_pc, link_addr, branch_count, mispredict_count;

  logic        v4 = 1'b0;
  logic        pt4, pcsrc4, flush4;
  logic [31:0] rpc4, link4;
  logic [3:0]  bc4, mc4;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_bht [BHT_N];
  int          m_busy;
  longint      m_bc, m_mc;
  logic [31:0] m_rpc;

  always #5 clock = ~clock;

  branch_resolve_unit dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .opCode(opCode), .funct3(funct3),
    .pc(pc), .imm(imm), .operand1(operand1), .operand2(operand2), .pred_taken(pred_taken),
    .fetch_pc(fetch_pc), .predict_taken(predict_taken), .PCsrc(PCsrc),
    .redirect_pc(redirect_pc), .flush(flush), .link_addr(link_addr),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_resolve_unit #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .valid_in(v4), .opCode(B_OP), .funct3(3'b000),
    .pc(32'h10), .imm(32'h4), .operand1(32'd5), .operand2(32'd5), .pred_taken(1'b0),
    .fetch_pc(32'h10), .predict_taken(pt4), .PCsrc(pcsrc4), .redirect_pc(rpc4),
    .flush(flush4), .link_addr(link4), .branch_count(bc4), .mispredict_count(mc4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return int'(a) <  int'(b);
      3'd5:    return int'(a) >= int'(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int bht_slot(input logic [31:0] addr);
    return int'((addr / 4) % BHT_N);
  endfunction

  task automatic model_reset();
    foreach (m_bht[i]) m_bht[i] = 1;
    m_busy = 0;
    m_bc   = 0;
    m_mc   = 0;
    m_rpc  = '0;
  endtask

  task automatic step(input logic v, input logic [6:0] op, input logic [2:0] f3,
                      input logic [31:0] p, input logic [31:0] im, input logic [31:0] a,
                      input logic [31:0] b, input logic pt, input logic [31:0] fpc);
    logic cond, is_br, is_jump, tk, exp_pcsrc;
    int   s;
    valid_in = v; opCode = op; funct3 = f3; pc = p; imm = im;
    operand1 = a; operand2 = b; pred_taken = pt; fetch_pc = fpc;
    #1;
    check("predict_taken", predict_taken, (m_bht[bht_slot(fpc)] >= 2));
    check("link_addr", link_addr, p + 32'd4);
    is_br     = (op == B_OP);
    is_jump   = (op == JAL_OP) || (op == JALR_OP);
    cond      = ref_cond(f3, a, b);
    tk        = is_jump || (is_br && cond);
    exp_pcsrc = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
    end else if (v) begin
      if (is_br) begin
        m_bc++;
        if (f3 != 3'd2 && f3 != 3'd3) begin
          s = bht_slot(p);
          m_bht[s] = cond ? ((m_bht[s] < 3) ? m_bht[s] + 1 : 3) : ((m_bht[s] > 0) ? m_bht[s] - 1 : 0);
        end
      end
      if (is_jump || (is_br && (cond != pt))) begin
        m_mc++;
        m_busy    = FLUSH_N;
        exp_pcsrc = 1'b1;
        if (!tk)                  m_rpc = p + 32'd4;
        else if (op == JALR_OP)   m_rpc = (a + im) & 32'hFFFF_FFFE;
        else                      m_rpc = p + im;
      end
    end
    @(posedge clock);
    #1;
    check("PCsrc", PCsrc, exp_pcsrc);
    check("flush", flush, (m_busy > 0));
    if (exp_pcsrc) check("redirect_pc", redirect_pc, m_rpc);
    check("branch_count", branch_count, m_bc);
    check("mispredict_count", mispredict_count, m_mc);
  endtask

  task automatic idle(input int n, input logic [31:0] fpc);
    for (int i = 0; i < n; i++) step(1'b0, ALU_OP, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, fpc);
  endtask

  initial begin
    logic [6:0]  r_op;
    logic [31:0] r_a, r_b;
    int          sel;

    // Reset state
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_PCsrc", PCsrc, 1'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_branch_count", branch_count, 32'h0);
    check("rst_mispredict_count", mispredict_count, 32'h0);
    check("rst_predict", predict_taken, 1'b0);
    check("rst_cnt4", {mc4, bc4}, 8'h00);
    reset = 1'b1;

    // beq taken, predicted not taken: redirect to pc+imm, flush two cycles
    step(1'b1, B_OP, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h100);
    check("t1_PCsrc", PCsrc, 1'b1);
    check("t1_redirect_pc", redirect_pc, 32'h120);
    idle(1, 32'h100);
    check("t1_flush_2nd", flush, 1'b1);
    check("t1_entry0_10", predict_taken, 1'b1);
    idle(1, 32'h100);
    check("t1_flush_done", flush, 1'b0);

    // Signed vs unsigned less-than with the same operands
    step(1'b1, B_OP, 3'd4, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h0);
    check("t2_blt_no_redirect", PCsrc, 1'b0);
    step(1'b1, B_OP, 3'd6, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h0);
    check("t2_bltu_redirect_pc", redirect_pc, 32'h204);
    idle(2, 32'h0);

    // jalr target clears bit 0; a jal in the flush shadow is ignored
    step(1'b1, JALR_OP, 3'd0, 32'h40, 32'h10, 32'h203, 32'h0, 1'b0, 32'h40);
    check("t3_jalr_target", redirect_pc, 32'h212);
    step(1'b1, JAL_OP, 3'd0, 32'h44, 32'h100, 32'h0, 32'h0, 1'b0, 32'h44);
    check("t3_jal_ignored_mc", mispredict_count, 32'd2 + 32'd1);
    idle(2, 32'h0);

    // Four taken bne at pc=0x8 saturate entry 2; alias one table-span higher
    for (int i = 0; i < 4; i++)
      step(1'b1, B_OP, 3'd1, 32'h8, 32'h40, 32'd1, 32'd2, 1'b1, 32'h8);
    idle(1, 32'h8);
    check("t4_predict_0x8", predict_taken, 1'b1);
    idle(1, 32'h8 + 32'(4 * BHT_N));
    check("t4_predict_alias", predict_taken, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      r_op = (sel < 6) ? B_OP : (sel == 6) ? JAL_OP : (sel == 7) ? JALR_OP : ALU_OP;
      r_a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom;
      r_b  = ($urandom_range(0, 2) == 0) ? r_a : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom);
      step(($urandom_range(0, 4) != 0), r_op, 3'($urandom_range(0, 7)),
           32'($urandom_range(0, 255)) << 2, $urandom, r_a, r_b,
           1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2);
    end
    idle(3, 32'h0);

    // Reset in the first flush cycle clears everything at that edge
    step(1'b1, JAL_OP, 3'd0, 32'h300, 32'h80, 32'h0, 32'h0, 1'b0, 32'h0);
    check("t5_flush_before", flush, 1'b1);
    reset = 1'b0;
    valid_in = 1'b0;
    @(posedge clock);
    #1;
    model_reset();
    check("t5_flush", flush, 1'b0);
    check("t5_PCsrc", PCsrc, 1'b0);
    check("t5_branch_count", branch_count, 32'h0);
    check("t5_mispredict_count", mispredict_count, 32'h0);
    reset = 1'b1;
    idle(2, 32'h8);

    // Narrow counters saturate at 15
    for (int i = 0; i < 20; i++) begin
      v4 = 1'b1;
      @(posedge clock);
      #1;
      v4 = 1'b0;
      if (i == 0) check("t6_first_redirect", pcsrc4, 1'b1);
      repeat (FLUSH_N) @(posedge clock);
      #1;
    end
    check("t6_mispredict_count", mc4, 4'd15);
    check("t6_branch_count", bc4, 4'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
